// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg
//   Shared definitions for the LA32R instruction encoder: the request
//   operation enumeration, the per-op opcode prefixes, the NOP word, the
//   immediate range limits and the FSM state type.
package inst_encoder_pkg;

    // Request operation codes. Values 39..63 are undefined and encode as an
    // error NOP.
    typedef enum logic [5:0] {
        OP_ADD_W     = 6'd0,
        OP_SUB_W     = 6'd1,
        OP_SLT       = 6'd2,
        OP_SLTU      = 6'd3,
        OP_AND       = 6'd4,
        OP_OR        = 6'd5,
        OP_XOR       = 6'd6,
        OP_SLL_W     = 6'd7,
        OP_SRL_W     = 6'd8,
        OP_SRA_W     = 6'd9,
        OP_SLLI_W    = 6'd10,
        OP_SRLI_W    = 6'd11,
        OP_SRAI_W    = 6'd12,
        OP_SLTI      = 6'd13,
        OP_SLTUI     = 6'd14,
        OP_ADDI_W    = 6'd15,
        OP_ANDI      = 6'd16,
        OP_ORI       = 6'd17,
        OP_XORI      = 6'd18,
        OP_LD_B      = 6'd19,
        OP_LD_H      = 6'd20,
        OP_LD_W      = 6'd21,
        OP_LD_BU     = 6'd22,
        OP_LD_HU     = 6'd23,
        OP_ST_B      = 6'd24,
        OP_ST_H      = 6'd25,
        OP_ST_W      = 6'd26,
        OP_LU12I_W   = 6'd27,
        OP_PCADDU12I = 6'd28,
        OP_JIRL      = 6'd29,
        OP_BEQ       = 6'd30,
        OP_BNE       = 6'd31,
        OP_BLT       = 6'd32,
        OP_BGE       = 6'd33,
        OP_BLTU      = 6'd34,
        OP_BGEU      = 6'd35,
        OP_B         = 6'd36,
        OP_BL        = 6'd37,
        OP_LI        = 6'd38
    } op_e;

    // Encoding format (also selects which range rule applies).
    typedef enum logic [3:0] {
        FMT_3R,
        FMT_2RI5,
        FMT_SI12,
        FMT_UI12,
        FMT_SI20,
        FMT_OFFS16,
        FMT_OFFS26,
        FMT_LI,
        FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_LI_2 = 2'd2
    } state_e;

    // andi r0, r0, 0
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    // Prefixes the LI expansion needs by name.
    localparam logic [31:0] PFX_ADDI_W  = 32'h0280_0000;
    localparam logic [31:0] PFX_ORI     = 32'h0380_0000;
    localparam logic [31:0] PFX_LU12I_W = 32'h1400_0000;

    // Immediate range limits (inclusive).
    localparam logic signed [31:0] SI12_MIN   = -32'sd2048;
    localparam logic signed [31:0] SI12_MAX   = 32'sd2047;
    localparam logic signed [31:0] UI12_MAX   = 32'sd4095;
    localparam logic signed [31:0] UI5_MAX    = 32'sd31;
    localparam logic signed [31:0] SI20_MIN   = -32'sd524288;
    localparam logic signed [31:0] SI20_MAX   = 32'sd524287;
    localparam logic signed [31:0] OFFS16_MIN = -32'sd131072;
    localparam logic signed [31:0] OFFS16_MAX = 32'sd131068;
    localparam logic signed [31:0] OFFS26_MIN = -32'sd134217728;
    localparam logic signed [31:0] OFFS26_MAX = 32'sd134217724;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic fmt_e op_format(input logic [5:0] op);
        case (op)
            OP_ADD_W, OP_SUB_W, OP_SLT, OP_SLTU, OP_AND, OP_OR, OP_XOR,
            OP_SLL_W, OP_SRL_W, OP_SRA_W:                 return FMT_3R;
            OP_SLLI_W, OP_SRLI_W, OP_SRAI_W:              return FMT_2RI5;
            OP_SLTI, OP_SLTUI, OP_ADDI_W,
            OP_LD_B, OP_LD_H, OP_LD_W, OP_LD_BU, OP_LD_HU,
            OP_ST_B, OP_ST_H, OP_ST_W:                    return FMT_SI12;
            OP_ANDI, OP_ORI, OP_XORI:                     return FMT_UI12;
            OP_LU12I_W, OP_PCADDU12I:                     return FMT_SI20;
            OP_JIRL, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
            OP_BLTU, OP_BGEU:                             return FMT_OFFS16;
            OP_B, OP_BL:                                  return FMT_OFFS26;
            OP_LI:                                        return FMT_LI;
            default:                                      return FMT_BAD;
        endcase
    endfunction

    // Fixed opcode bits of each op; operand fields are ORed in below them.
    function automatic logic [31:0] op_prefix(input logic [5:0] op);
        case (op)
            OP_ADD_W:     return 32'h0010_0000;
            OP_SUB_W:     return 32'h0011_0000;
            OP_SLT:       return 32'h0012_0000;
            OP_SLTU:      return 32'h0012_8000;
            OP_AND:       return 32'h0014_8000;
            OP_OR:        return 32'h0015_0000;
            OP_XOR:       return 32'h0015_8000;
            OP_SLL_W:     return 32'h0017_0000;
            OP_SRL_W:     return 32'h0017_8000;
            OP_SRA_W:     return 32'h0018_0000;
            OP_SLLI_W:    return 32'h0040_8000;
            OP_SRLI_W:    return 32'h0044_8000;
            OP_SRAI_W:    return 32'h0048_8000;
            OP_SLTI:      return 32'h0200_0000;
            OP_SLTUI:     return 32'h0240_0000;
            OP_ADDI_W:    return PFX_ADDI_W;
            OP_ANDI:      return 32'h0340_0000;
            OP_ORI:       return PFX_ORI;
            OP_XORI:      return 32'h03C0_0000;
            OP_LD_B:      return 32'h2800_0000;
            OP_LD_H:      return 32'h2840_0000;
            OP_LD_W:      return 32'h2880_0000;
            OP_ST_B:      return 32'h2900_0000;
            OP_ST_H:      return 32'h2940_0000;
            OP_ST_W:      return 32'h2980_0000;
            OP_LD_BU:     return 32'h2A00_0000;
            OP_LD_HU:     return 32'h2A40_0000;
            OP_LU12I_W:   return PFX_LU12I_W;
            OP_PCADDU12I: return 32'h1C00_0000;
            OP_JIRL:      return 32'h4C00_0000;
            OP_B:         return 32'h5000_0000;
            OP_BL:        return 32'h5400_0000;
            OP_BEQ:       return 32'h5800_0000;
            OP_BNE:       return 32'h5C00_0000;
            OP_BLT:       return 32'h6000_0000;
            OP_BGE:       return 32'h6400_0000;
            OP_BLTU:      return 32'h6800_0000;
            OP_BGEU:      return 32'h6C00_0000;
            default:      return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/inst_format.sv
// inst_format
//   Combinational encoder: turns one request into its instruction word,
//   checks the immediate range and, for LI, produces the optional ORI word.
// Ports
//   op, rd, rj, rk, imm : request fields
//   word                : encoded word (NOP on error)
//   err                 : range violation or undefined op
//   needs_second        : LI expansion owes a second (ORI) word
//   second_word         : that ORI word
module inst_format
    import inst_encoder_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rj,
    input  logic [4:0]  rk,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err,
    output logic        needs_second,
    output logic [31:0] second_word
);

    logic signed [31:0] simm;
    fmt_e               fmt;
    logic [31:0]        base;
    logic [31:0]        body;
    logic               ok;
    logic               li_short;

    assign simm     = imm;
    assign fmt      = op_format(op);
    assign li_short = in_range(simm, SI12_MIN, SI12_MAX);

    always_comb begin
        ok           = 1'b0;
        base         = op_prefix(op);
        body         = '0;
        needs_second = 1'b0;
        second_word  = NOP_INST;
        case (fmt)
            FMT_3R: begin
                ok   = 1'b1;
                body = {17'd0, rk, rj, rd};
            end
            FMT_2RI5: begin
                ok   = in_range(simm, 32'sd0, UI5_MAX);
                body = {17'd0, imm[4:0], rj, rd};
            end
            FMT_SI12: begin
                ok   = in_range(simm, SI12_MIN, SI12_MAX);
                body = {10'd0, imm[11:0], rj, rd};
            end
            FMT_UI12: begin
                ok   = in_range(simm, 32'sd0, UI12_MAX);
                body = {10'd0, imm[11:0], rj, rd};
            end
            FMT_SI20: begin
                ok   = in_range(simm, SI20_MIN, SI20_MAX);
                body = {7'd0, imm[19:0], rd};
            end
            FMT_OFFS16: begin
                ok   = (imm[1:0] == 2'b00) && in_range(simm, OFFS16_MIN, OFFS16_MAX);
                body = {6'd0, imm[17:2], rj, rd};
            end
            FMT_OFFS26: begin
                // offs[15:0] sits high, offs[25:16] low (I26 split layout).
                ok   = (imm[1:0] == 2'b00) && in_range(simm, OFFS26_MIN, OFFS26_MAX);
                body = {6'd0, imm[17:2], imm[27:18]};
            end
            FMT_LI: begin
                // Short form: addi.w rd, r0, imm. Long form: lu12i.w with
                // the upper 20 bits, then ori only if low bits are non-zero.
                ok = 1'b1;
                if (li_short) begin
                    base = PFX_ADDI_W;
                    body = {10'd0, imm[11:0], 5'd0, rd};
                end else begin
                    base         = PFX_LU12I_W;
                    body         = {7'd0, imm[31:12], rd};
                    needs_second = (imm[11:0] != 12'd0);
                    second_word  = PFX_ORI | {10'd0, imm[11:0], rd, rd};
                end
            end
            default: ok = 1'b0;
        endcase
    end

    assign word = ok ? (base | body) : NOP_INST;
    assign err  = ~ok;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
//   Registered LA32R encoder. Accepts one request at a time, emits one or
//   (for a long LI) two instruction words through an output register.
// Ports
//   clk, rstn                      : clock, async active-low reset
//   req_valid/req_ready            : request handshake
//   req_op, req_rd, req_rj, req_rk : op code and register fields
//   req_imm                        : immediate / byte offset (two's complement)
//   out_valid/out_ready            : output handshake
//   out_inst, out_err, out_last    : encoded word, range error, final word flag
//   state_dbg                      : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; out_inst/out_err/out_last never change while out_valid=1 and
// out_ready=0.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rj,
    input  logic [4:0]  req_rk,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last,
    output logic [1:0]  state_dbg
);

    state_e      state;
    state_e      state_nxt;
    logic        ready_int;
    logic        load_req;
    logic        load_pend;
    logic        second_owed;
    logic [31:0] pend_word;

    logic [31:0] fmt_word;
    logic        fmt_err;
    logic        fmt_second;
    logic [31:0] fmt_second_word;

    inst_format u_format (
        .op           (req_op),
        .rd           (req_rd),
        .rj           (req_rj),
        .rk           (req_rk),
        .imm          (req_imm),
        .word         (fmt_word),
        .err          (fmt_err),
        .needs_second (fmt_second),
        .second_word  (fmt_second_word)
    );

    // The word in the output register is the first of a long LI exactly
    // when it is not marked last.
    assign second_owed = ~out_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_int = 1'b0;
        load_req  = 1'b0;
        load_pend = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (req_valid) begin
                    load_req  = 1'b1;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (second_owed) begin
                        state_nxt = ST_LI_2;
                    end else begin
                        ready_int = 1'b1;
                        if (req_valid) begin
                            load_req = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_LI_2: begin
                load_pend = 1'b1;
                state_nxt = ST_EMIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Gated with rstn so the block never advertises ready while held in reset.
    assign req_ready = ready_int & rstn;
    assign out_valid = (state == ST_EMIT);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_inst  <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            pend_word <= '0;
        end else if (load_req) begin
            out_inst  <= fmt_word;
            out_err   <= fmt_err;
            out_last  <= ~fmt_second;
            pend_word <= fmt_second_word;
        end else if (load_pend) begin
            out_inst  <= pend_word;
            out_err   <= 1'b0;
            out_last  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rj = '0;
    logic [4:0]  req_rk = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rj    (req_rj),
        .req_rk    (req_rk),
        .req_imm   (req_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_last  (out_last),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Built from the ISA field layout with plain integer arithmetic.
    localparam int K3R = 0, K5 = 1, KS12 = 2, KU12 = 3, KS20 = 4,
                   KO16 = 5, KO26 = 6, KLI = 7, KBAD = 8;

    function automatic void ref_encode(input int op, input int rd, input int rj,
                                       input int rk, input int imm,
                                       output int n, output logic [31:0] w0,
                                       output logic [31:0] w1, output logic e);
        int kind;
        int opc;
        int offs;
        int lo;
        logic [31:0] u;
        kind = KBAD;
        opc  = 0;
        u    = imm;
        case (op)
            OP_ADD_W:     begin kind = K3R;  opc = 'h20; end
            OP_SUB_W:     begin kind = K3R;  opc = 'h22; end
            OP_SLT:       begin kind = K3R;  opc = 'h24; end
            OP_SLTU:      begin kind = K3R;  opc = 'h25; end
            OP_AND:       begin kind = K3R;  opc = 'h29; end
            OP_OR:        begin kind = K3R;  opc = 'h2A; end
            OP_XOR:       begin kind = K3R;  opc = 'h2B; end
            OP_SLL_W:     begin kind = K3R;  opc = 'h2E; end
            OP_SRL_W:     begin kind = K3R;  opc = 'h2F; end
            OP_SRA_W:     begin kind = K3R;  opc = 'h30; end
            OP_SLLI_W:    begin kind = K5;   opc = 'h81; end
            OP_SRLI_W:    begin kind = K5;   opc = 'h89; end
            OP_SRAI_W:    begin kind = K5;   opc = 'h91; end
            OP_SLTI:      begin kind = KS12; opc = 'h08; end
            OP_SLTUI:     begin kind = KS12; opc = 'h09; end
            OP_ADDI_W:    begin kind = KS12; opc = 'h0A; end
            OP_ANDI:      begin kind = KU12; opc = 'h0D; end
            OP_ORI:       begin kind = KU12; opc = 'h0E; end
            OP_XORI:      begin kind = KU12; opc = 'h0F; end
            OP_LD_B:      begin kind = KS12; opc = 'hA0; end
            OP_LD_H:      begin kind = KS12; opc = 'hA1; end
            OP_LD_W:      begin kind = KS12; opc = 'hA2; end
            OP_ST_B:      begin kind = KS12; opc = 'hA4; end
            OP_ST_H:      begin kind = KS12; opc = 'hA5; end
            OP_ST_W:      begin kind = KS12; opc = 'hA6; end
            OP_LD_BU:     begin kind = KS12; opc = 'hA8; end
            OP_LD_HU:     begin kind = KS12; opc = 'hA9; end
            OP_LU12I_W:   begin kind = KS20; opc = 'h0A; end
            OP_PCADDU12I: begin kind = KS20; opc = 'h0E; end
            OP_JIRL:      begin kind = KO16; opc = 'h13; end
            OP_BEQ:       begin kind = KO16; opc = 'h16; end
            OP_BNE:       begin kind = KO16; opc = 'h17; end
            OP_BLT:       begin kind = KO16; opc = 'h18; end
            OP_BGE:       begin kind = KO16; opc = 'h19; end
            OP_BLTU:      begin kind = KO16; opc = 'h1A; end
            OP_BGEU:      begin kind = KO16; opc = 'h1B; end
            OP_B:         begin kind = KO26; opc = 'h14; end
            OP_BL:        begin kind = KO26; opc = 'h15; end
            OP_LI:        begin kind = KLI;  opc = 0;     end
            default:      begin kind = KBAD; opc = 0;     end
        endcase
        n  = 1;
        w0 = 32'h0340_0000;
        w1 = 32'h0;
        e  = 1'b0;
        case (kind)
            K3R:  w0 = opc * 32768 + rk * 1024 + rj * 32 + rd;
            K5:   if (imm >= 0 && imm <= 31) w0 = opc * 32768 + imm * 1024 + rj * 32 + rd;
                  else e = 1'b1;
            KS12: if (imm >= -2048 && imm <= 2047)
                      w0 = opc * 4194304 + (imm & 4095) * 1024 + rj * 32 + rd;
                  else e = 1'b1;
            KU12: if (imm >= 0 && imm <= 4095)
                      w0 = opc * 4194304 + imm * 1024 + rj * 32 + rd;
                  else e = 1'b1;
            KS20: if (imm >= -524288 && imm <= 524287)
                      w0 = opc * 33554432 + (imm & 'hFFFFF) * 32 + rd;
                  else e = 1'b1;
            KO16: if (imm % 4 == 0 && imm >= -131072 && imm <= 131068)
                      w0 = opc * 67108864 + ((imm / 4) & 'hFFFF) * 1024 + rj * 32 + rd;
                  else e = 1'b1;
            KO26: if (imm % 4 == 0 && imm >= -134217728 && imm <= 134217724) begin
                      offs = (imm / 4) & 'h3FFFFFF;
                      w0 = opc * 67108864 + (offs % 65536) * 1024 + offs / 65536;
                  end else e = 1'b1;
            KLI: begin
                if (imm >= -2048 && imm <= 2047) begin
                    w0 = 'h0A * 4194304 + (imm & 4095) * 1024 + rd;
                end else begin
                    w0 = 'h0A * 33554432 + (u >> 12) * 32 + rd;
                    lo = imm & 4095;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = 'h0E * 4194304 + lo * 1024 + rd * 32 + rd;
                    end
                end
            end
            default: e = 1'b1;
        endcase
        if (e) w0 = 32'h0340_0000;
    endfunction

    // ---------------- scoreboard (random phase) ----------------
    logic [33:0] exp_q[$];
    bit          sb_on = 1'b0;
    logic        stall_prev = 1'b0;
    logic [33:0] stall_word = '0;

    always @(negedge clk) begin
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        e;
        logic [33:0] exp_v;
        if (sb_on) begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_word", {out_err, out_last, out_inst}, stall_word);
            end
            stall_prev <= out_valid && !out_ready;
            stall_word <= {out_err, out_last, out_inst};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", {out_err, out_last, out_inst}, 34'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sb_word", {out_err, out_last, out_inst}, exp_v);
                end
            end
            if (req_valid && req_ready) begin
                ref_encode(int'(req_op), int'(req_rd), int'(req_rj), int'(req_rk),
                           int'(req_imm), n, w0, w1, e);
                exp_q.push_back({e, (n == 1), w0});
                if (n == 2) exp_q.push_back({1'b0, 1'b1, w1});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns #1 after the edge that accepted the request, with req_valid low.
    task automatic send_req(input int op, input int rd, input int rj, input int rk, input int imm);
        bit ok;
        @(posedge clk); #1;
        req_op = op[5:0]; req_rd = rd[4:0]; req_rj = rj[4:0]; req_rk = rk[4:0];
        req_imm = imm; req_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        int          op;
        int          rd;
        int          rj;
        int          rk;
        int          imm;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   bnd[22] = '{-2049, -2048, 2047, 2048, 4095, 4096, 31, 32, -1, 0, 131068,
                      131072, -131072, -131076, 134217724, 134217728, -134217728,
                      524287, 524288, -524288, -524289, 2};

    task automatic run_vec(input int i, input vec_t v);
        send_req(v.op, v.rd, v.rj, v.rk, v.imm);
        @(negedge clk);
        check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
        check($sformatf("vec%0d_w0", i), out_inst, v.w0);
        check($sformatf("vec%0d_err", i), out_err, v.err);
        check($sformatf("vec%0d_last0", i), out_last, (v.n == 1));
        if (v.n == 2) begin
            check($sformatf("vec%0d_ready_w0", i), req_ready, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_gap_valid", i), out_valid, 1'b0);
            check($sformatf("vec%0d_gap_ready", i), req_ready, 1'b0);
            check($sformatf("vec%0d_gap_state", i), state_dbg, ST_LI_2);
            @(negedge clk);
            check($sformatf("vec%0d_valid1", i), out_valid, 1'b1);
            check($sformatf("vec%0d_w1", i), out_inst, v.w1);
            check($sformatf("vec%0d_last1", i), out_last, 1'b1);
        end
        @(negedge clk);
        check($sformatf("vec%0d_done", i), out_valid, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit acc;
        int sel;
        int imm;

        // Reset state
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_inst", out_inst, 32'h0);
        check("rst_err", out_err, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);

        // Directed vectors, consumer always ready
        vecs.push_back('{OP_ADD_W, 3, 1, 2, 0, 1, 32'h0010_0823, 32'h0, 1'b0});
        vecs.push_back('{OP_ADDI_W, 1, 0, 0, -1, 1, 32'h02BF_FC01, 32'h0, 1'b0});
        vecs.push_back('{OP_ADDI_W, 1, 0, 0, 4096, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_LI, 5, 0, 0, 32'h1234_5678, 2, 32'h1424_68A5, 32'h0399_E0A5, 1'b0});
        vecs.push_back('{OP_LI, 5, 0, 0, 32'h1234_5000, 1, 32'h1424_68A5, 32'h0, 1'b0});
        vecs.push_back('{OP_LI, 5, 0, 0, -5, 1, 32'h02BF_EC05, 32'h0, 1'b0});
        vecs.push_back('{OP_ANDI, 2, 3, 0, 4095, 1, 32'h037F_FC62, 32'h0, 1'b0});
        vecs.push_back('{OP_ANDI, 2, 3, 0, -1, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_SLLI_W, 4, 5, 0, 31, 1, 32'h0040_FCA4, 32'h0, 1'b0});
        vecs.push_back('{OP_SLLI_W, 4, 5, 0, 32, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_BEQ, 2, 1, 0, -4, 1, 32'h5BFF_FC22, 32'h0, 1'b0});
        vecs.push_back('{OP_BEQ, 2, 1, 0, 2, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_BEQ, 2, 1, 0, 131068, 1, 32'h59FF_FC22, 32'h0, 1'b0});
        vecs.push_back('{OP_BEQ, 2, 1, 0, 131072, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_B, 0, 0, 0, -134217728, 1, 32'h5000_0200, 32'h0, 1'b0});
        vecs.push_back('{OP_B, 0, 0, 0, 8, 1, 32'h5000_0800, 32'h0, 1'b0});
        vecs.push_back('{OP_LU12I_W, 7, 0, 0, -524288, 1, 32'h1500_0007, 32'h0, 1'b0});
        vecs.push_back('{OP_LU12I_W, 7, 0, 0, 524288, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{63, 1, 2, 3, 0, 1, 32'h0340_0000, 32'h0, 1'b1});
        vecs.push_back('{OP_ST_W, 4, 3, 0, -2048, 1, 32'h29A0_0064, 32'h0, 1'b0});
        vecs.push_back('{OP_SUB_W, 31, 31, 31, 0, 1, 32'h0011_7FFF, 32'h0, 1'b0});
        out_ready = 1'b1;
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-pressure: output stalled 4 cycles with a second request waiting
        out_ready = 1'b0;
        send_req(OP_ADD_W, 3, 1, 2, 0);
        req_op = OP_OR; req_rd = 5'd6; req_rj = 5'd7; req_rk = 5'd8; req_imm = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", c), out_valid, 1'b1);
            check($sformatf("stall%0d_inst", c), out_inst, 32'h0010_0823);
            check($sformatf("stall%0d_ready", c), req_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_second_valid", out_valid, 1'b1);
        check("stall_second_inst", out_inst, 32'h0015_20E6);
        @(negedge clk);
        check("stall_drained", out_valid, 1'b0);

        // Reset in the middle of a two-word LI
        send_req(OP_LI, 5, 0, 0, 32'h1234_5678);
        @(negedge clk);
        check("midli_w0", out_inst, 32'h1424_68A5);
        check("midli_last0", out_last, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("midli_rst_valid", out_valid, 1'b0);
        check("midli_rst_ready", req_ready, 1'b0);
        check("midli_rst_state", state_dbg, ST_IDLE);
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midli_post_ready", req_ready, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("midli_no_ori%0d", c), out_valid, 1'b0);
            @(negedge clk);
        end

        // Randomized traffic with random back-pressure against the model
        @(posedge clk); #1;
        sb_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            sel = $urandom_range(0, 4);
            case (sel)
                0: imm = int'($urandom_range(0, 63)) - 32;
                1: imm = bnd[$urandom_range(0, 21)];
                2: imm = int'($urandom);
                3: imm = (int'($urandom_range(0, 131071)) - 65536) * 4;
                default: imm = int'($urandom_range(0, 2097151)) - 1048576;
            endcase
            if ($urandom_range(0, 99) < 8) req_op = 6'($urandom_range(39, 63));
            else req_op = 6'($urandom_range(0, 38));
            req_rd = 5'($urandom_range(0, 31));
            req_rj = 5'($urandom_range(0, 31));
            req_rk = 5'($urandom_range(0, 31));
            req_imm = imm;
            req_valid = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 40 && !acc; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = req_ready;
                @(posedge clk); #1;
            end
            if (!acc) check("rand_accept_timeout", 1'b0, 1'b1);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        sb_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port req_valid, input, 1 bit: an encode request is present.
REQ-004 The block SHALL have the port req_ready, output, 1 bit: the request is accepted this cycle when high together with req_valid.
REQ-005 The block SHALL have the port req_op, input, 6 bits: operation code from the shared enumeration (LA32R subset plus the LI pseudo-op).
REQ-006 The block SHALL have the ports req_rd, req_rj and req_rk, inputs, 5 bits each: register fields.
REQ-007 The block SHALL have the port req_imm, input, 32 bits: the immediate or byte offset as a two's-complement value.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: out_inst holds a valid encoded word.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the word.
REQ-010 The block SHALL have the port out_inst, output, 32 bits: the encoded instruction word.
REQ-011 The block SHALL have the port out_err, output, 1 bit: the immediate was out of range, and out_inst is NOP.
REQ-012 The block SHALL have the port out_last, output, 1 bit: this word is the final word of its request.

Function
REQ-013 The block SHALL encode every op in its format:
- 3R: 17-bit opcode, rk, rj, rd (ADD_W, SUB_W, SLT, SLTU, AND, OR, XOR, SLL_W, SRL_W, SRA_W).
- 2RI5: SLLI_W, SRLI_W, SRAI_W.
- 2RI12: SLTI, SLTUI, ADDI_W, ANDI, ORI, XORI, and all LD and ST forms.
- 1RI20: LU12I_W, PCADDU12I.
- 2RI16: JIRL, BEQ, BNE, BLT, BGE, BLTU, BGEU.
- I26: B, BL, with offs[15:0] in bits [25:10] and offs[25:16] in bits [9:0].
REQ-014 For branches and stores the block SHALL place req_rd in bits [4:0] and req_rj in bits [9:5].
REQ-015 The block SHALL apply these range rules:
- si12: -2048..2047.
- ui12 (ANDI, ORI, XORI): 0..4095.
- ui5: 0..31.
- si20 (LU12I_W, PCADDU12I): -2^19..2^19-1; req_imm is the raw field value, not shifted.
- offs16: byte offset that is a multiple of 4 and within -2^17..2^17-4; the encoded field is offset>>2.
- offs26: byte offset that is a multiple of 4 and within -2^27..2^27-4.
REQ-016 On a range violation or an undefined req_op, the block SHALL emit 32'h0340_0000 (andi r0,r0,0) with out_err=1 and out_last=1.
REQ-017 For LI, if req_imm fits si12, the block SHALL emit a single word: ADDI_W rd, r0, imm.
REQ-018 For LI otherwise, the block SHALL emit LU12I_W rd, imm[31:12]; then, only if imm[11:0]!=0, it SHALL emit ORI rd, rd, imm[11:0].
REQ-019 The block SHALL use three states: IDLE, EMIT (output register full), and LI_2 (the second LI word is pending).
REQ-020 State transitions SHALL be:
- IDLE to EMIT on accept.
- EMIT to LI_2 when the word is consumed and a second word is owed.
- EMIT to IDLE when the word is consumed and no accept occurs the same cycle.
- EMIT to EMIT when the word is consumed and a new request is accepted the same cycle.
- LI_2 to EMIT, loading the ORI word, the next cycle.
REQ-021 req_ready SHALL be high iff state is IDLE, or state is EMIT with out_ready=1 and no second LI word owed.
REQ-022 Latency SHALL be one cycle from accept to out_valid; throughput SHALL be one word per cycle for single-word ops under continuous out_ready.
REQ-023 While out_valid=1 and out_ready=0, out_inst, out_err and out_last SHALL hold stable.
REQ-024 For a two-word LI, out_last SHALL be 0 on the first word and 1 on the second.
REQ-025 Register fields SHALL pass through unchanged, with no r0 checks.

Reset
REQ-026 While rstn=0, the block SHALL hold state=IDLE, out_valid=0, out_inst=0, out_err=0, out_last=0 and req_ready=0.
REQ-027 The first cycle after rstn deasserts, req_ready SHALL be 1.
REQ-028 Reset asserted mid-LI SHALL discard the pending second word, with no word emitted after reset.

Structure
REQ-029 A shared package SHALL hold the req_op enumeration, the per-op opcode prefixes, the NOP constant and the range limits.
REQ-030 The encoding SHALL be a combinational sub-module inst_format (op, rd, rj, rk, imm to word, err, needs_second); inst_encoder SHALL hold the FSM and output register.

Verification
REQ-031 The bench SHALL check: ADD_W rd=3 rj=1 rk=2 -> 32'h0010_0823 one cycle later, out_last=1.
REQ-032 The bench SHALL check: ADDI_W rd=1 rj=0 imm=-1 -> 32'h02BF_FC01; imm=4096 -> 32'h0340_0000 with out_err=1.
REQ-033 The bench SHALL check: LI rd=5 imm=32'h1234_5678 -> 32'h1424_68A5 (last=0), then 32'h0399_E0A5 (last=1), and req_ready=0 between the two words.
REQ-034 The bench SHALL check: LI rd=5 imm=32'h1234_5000 -> only 32'h1424_68A5 with last=1; LI imm=-5 -> single ADDI_W word.
REQ-035 The bench SHALL check: out_ready held low for 4 cycles with req_valid high -> out_inst stable, req_ready=0, and no request lost.
REQ-036 The bench SHALL check: rstn pulsed low after the first LI word -> out_valid=0 immediately, and no ORI word afterward.
